// File: rtl/rob_broadcast_commit.sv
// Reorder buffer: in-order allocate/commit, one FU result per cycle broadcast to the RSs,
// squash on mispredicted-branch retire. Define ROB_BCAST_BYPASS_EN for a combinational broadcast.

module rob_entry #(
    parameter int VAL_W = 64,
    parameter int REG_W = 5
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             alloc_we,
    input  logic [REG_W-1:0] alloc_dst,
    input  logic             alloc_nzcv,
    input  logic             cpl_we,
    input  logic [VAL_W-1:0] cpl_value,
    input  logic             cpl_mispred,
    input  logic             clr,
    output logic             valid,
    output logic             done,
    output logic             mispred,
    output logic             set_nzcv,
    output logic [REG_W-1:0] dst,
    output logic [VAL_W-1:0] value
);
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            valid    <= 1'b0;
            done     <= 1'b0;
            mispred  <= 1'b0;
            set_nzcv <= 1'b0;
            dst      <= '0;
            value    <= '0;
        end else if (clr) begin
            valid <= 1'b0;
            done  <= 1'b0;
        end else begin
            // alloc needs an invalid entry and completion a valid one, so they never collide
            if (alloc_we) begin
                valid    <= 1'b1;
                done     <= 1'b0;
                dst      <= alloc_dst;
                set_nzcv <= alloc_nzcv;
            end
            if (cpl_we) begin
                done    <= 1'b1;
                value   <= cpl_value;
                mispred <= cpl_mispred;
            end
        end
    end
endmodule

module rob_broadcast_commit #(
    parameter int ROB_SIZE = 16,
    parameter int IDX_W    = 4,
    parameter int VAL_W    = 64,
    parameter int REG_W    = 5
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_dispatch_valid,
    input  logic [REG_W-1:0] in_dispatch_dst,
    input  logic             in_dispatch_set_nzcv,
    output logic             out_dispatch_ready,
    output logic [IDX_W-1:0] out_alloc_index,
    input  logic [IDX_W-1:0] in_lookup_index,
    output logic             out_lookup_done,
    output logic [VAL_W-1:0] out_lookup_value,
    input  logic             in_fu_done,
    input  logic [IDX_W-1:0] in_fu_rob_index,
    input  logic [VAL_W-1:0] in_fu_value,
    input  logic             in_fu_mispred,
    output logic             out_rob_broadcast_done,
    output logic [IDX_W-1:0] out_rob_broadcast_index,
    output logic [VAL_W-1:0] out_rob_broadcast_val,
    output logic             out_rob_is_mispred,
    output logic             out_commit_valid,
    output logic [REG_W-1:0] out_commit_dst,
    output logic [VAL_W-1:0] out_commit_value,
    output logic             out_commit_set_nzcv,
    output logic             out_flush
);
    localparam logic [IDX_W:0] FULL = (IDX_W+1)'(ROB_SIZE);

    logic [IDX_W-1:0] head_q, tail_q;
    logic [IDX_W:0]   count_q;

    logic [ROB_SIZE-1:0]            e_valid, e_done, e_mispred, e_nzcv;
    logic [ROB_SIZE-1:0][REG_W-1:0] e_dst;
    logic [ROB_SIZE-1:0][VAL_W-1:0] e_val;

    logic alloc, cpl, commit, do_flush;
    logic stored_done;

    // ready is held low while reset is asserted so every output reads 0 during reset
    assign out_dispatch_ready = in_rst & (count_q != FULL) & ~out_flush;
    assign out_alloc_index    = tail_q;

    assign alloc    = in_dispatch_valid & out_dispatch_ready;
    assign cpl      = in_fu_done & e_valid[in_fu_rob_index] & ~out_flush;
    assign commit   = e_valid[head_q] & e_done[head_q];
    assign do_flush = commit & e_mispred[head_q];

    for (genvar i = 0; i < ROB_SIZE; i++) begin : g_ent
        rob_entry #(.VAL_W(VAL_W), .REG_W(REG_W)) u_ent (
            .in_clk      (in_clk),
            .in_rst      (in_rst),
            .alloc_we    (alloc && (tail_q == IDX_W'(i))),
            .alloc_dst   (in_dispatch_dst),
            .alloc_nzcv  (in_dispatch_set_nzcv),
            .cpl_we      (cpl && (in_fu_rob_index == IDX_W'(i))),
            .cpl_value   (in_fu_value),
            .cpl_mispred (in_fu_mispred),
            .clr         (do_flush | (commit && (head_q == IDX_W'(i)))),
            .valid       (e_valid[i]),
            .done        (e_done[i]),
            .mispred     (e_mispred[i]),
            .set_nzcv    (e_nzcv[i]),
            .dst         (e_dst[i]),
            .value       (e_val[i])
        );
    end

    assign stored_done = e_valid[in_lookup_index] & e_done[in_lookup_index];

`ifdef ROB_BCAST_BYPASS_EN
    logic fwd;
    assign fwd              = cpl && (in_fu_rob_index == in_lookup_index);
    assign out_lookup_done  = fwd | stored_done;
    assign out_lookup_value = fwd ? in_fu_value : (stored_done ? e_val[in_lookup_index] : '0);

    assign out_rob_broadcast_done  = cpl;
    assign out_rob_broadcast_index = cpl ? in_fu_rob_index : '0;
    assign out_rob_broadcast_val   = cpl ? in_fu_value : '0;
    assign out_rob_is_mispred      = cpl & in_fu_mispred;
`else
    logic bc;
    assign out_lookup_done  = stored_done;
    assign out_lookup_value = stored_done ? e_val[in_lookup_index] : '0;

    // a completion racing a squash is dropped so nothing stale reaches the RSs during flush
    assign bc = cpl & ~do_flush;

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            out_rob_broadcast_done  <= 1'b0;
            out_rob_broadcast_index <= '0;
            out_rob_broadcast_val   <= '0;
            out_rob_is_mispred      <= 1'b0;
        end else begin
            out_rob_broadcast_done  <= bc;
            out_rob_broadcast_index <= bc ? in_fu_rob_index : '0;
            out_rob_broadcast_val   <= bc ? in_fu_value : '0;
            out_rob_is_mispred      <= bc & in_fu_mispred;
        end
    end
`endif

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            head_q              <= '0;
            tail_q              <= '0;
            count_q             <= '0;
            out_commit_valid    <= 1'b0;
            out_commit_dst      <= '0;
            out_commit_value    <= '0;
            out_commit_set_nzcv <= 1'b0;
            out_flush           <= 1'b0;
        end else begin
            out_commit_valid    <= commit;
            out_commit_dst      <= commit ? e_dst[head_q] : '0;
            out_commit_value    <= commit ? e_val[head_q] : '0;
            out_commit_set_nzcv <= commit & e_nzcv[head_q];
            out_flush           <= do_flush;
            if (do_flush) begin
                head_q  <= head_q + IDX_W'(1);
                tail_q  <= head_q + IDX_W'(1);
                count_q <= '0;
            end else begin
                head_q  <= head_q + IDX_W'(commit);
                tail_q  <= tail_q + IDX_W'(alloc);
                count_q <= count_q + (IDX_W+1)'(alloc) - (IDX_W+1)'(commit);
            end
        end
    end
endmodule
